// File: rtl/mem_reduce_scan_if.sv
// rtl/mem_reduce_scan_if.sv - command, status and memory-port bundle for mem_reduce_scan
interface mem_reduce_scan_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
);
  localparam int LOGDEPTH = $clog2(DEPTH);

  logic                start;
  logic [1:0]          mode;
  logic [LOGDEPTH-1:0] base_addr;
  logic [LOGDEPTH:0]   length;
  logic [LOGDEPTH-1:0] dst_addr;

  logic [LOGDEPTH-1:0] mem_addr;
  logic                mem_re;
  logic [WIDTH-1:0]    mem_rdata;
  logic                mem_we;
  logic [WIDTH-1:0]    mem_wdata;

  logic                busy;
  logic                done;
  logic                err;
  logic [WIDTH-1:0]    result;
  logic [LOGDEPTH-1:0] result_idx;

  modport slave (
    input  start, mode, base_addr, length, dst_addr, mem_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata, busy, done, err, result, result_idx
  );

  modport master (
    output start, mode, base_addr, length, dst_addr, mem_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata, busy, done, err, result, result_idx
  );
endinterface

// File: rtl/mem_reduce_scan.sv
// rtl/mem_reduce_scan.sv - windowed max/min reduction over a synchronous-read memory
// Reads a wrapping window, tracks the first extreme value and its offset, writes it back.
module mem_reduce_scan #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_reduce_scan_if.slave bus
);
  localparam int LOGDEPTH = $clog2(DEPTH);
  localparam logic [LOGDEPTH:0] DEPTH_W = (LOGDEPTH+1)'(DEPTH);
  localparam logic [LOGDEPTH:0] ONE_W   = (LOGDEPTH+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q,  state_d;
  logic [1:0]          mode_q,   mode_d;
  logic [LOGDEPTH-1:0] base_q,   base_d;
  logic [LOGDEPTH:0]   len_q,    len_d;
  logic [LOGDEPTH-1:0] dst_q,    dst_d;
  logic [LOGDEPTH-1:0] i_q,      i_d;
  logic                err_q,    err_d;
  logic                vld_q,    vld_d;
  logic [LOGDEPTH-1:0] sidx_q,   sidx_d;
  logic                first_q,  first_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [LOGDEPTH-1:0] ridx_q,   ridx_d;

  logic                len_bad;
  logic                last_rd;
  logic [WIDTH-1:0]    msb_mask;
  logic [WIDTH-1:0]    key_new;
  logic [WIDTH-1:0]    key_cur;
  logic                better;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      dst_q    <= '0;
      i_q      <= '0;
      err_q    <= 1'b0;
      vld_q    <= 1'b0;
      sidx_q   <= '0;
      first_q  <= 1'b0;
      result_q <= '0;
      ridx_q   <= '0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      len_q    <= len_d;
      dst_q    <= dst_d;
      i_q      <= i_d;
      err_q    <= err_d;
      vld_q    <= vld_d;
      sidx_q   <= sidx_d;
      first_q  <= first_d;
      result_q <= result_d;
      ridx_q   <= ridx_d;
    end
  end

  assign len_bad = (bus.length == '0) || (bus.length > DEPTH_W);
  assign last_rd = ({1'b0, i_q} == (len_q - ONE_W));

  // Flipping the MSB maps two's-complement order onto unsigned order.
  assign msb_mask = {mode_q[1], {(WIDTH-1){1'b0}}};
  assign key_new  = bus.mem_rdata ^ msb_mask;
  assign key_cur  = result_q ^ msb_mask;
  assign better   = mode_q[0] ? (key_new < key_cur) : (key_new > key_cur);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    len_d    = len_q;
    dst_d    = dst_q;
    i_d      = i_q;
    err_d    = err_q;
    first_d  = first_q;
    result_d = result_q;
    ridx_d   = ridx_q;
    vld_d    = (state_q == S_READ);
    sidx_d   = i_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          base_d  = bus.base_addr;
          len_d   = bus.length;
          dst_d   = bus.dst_addr;
          i_d     = '0;
          first_d = 1'b1;
          err_d   = len_bad;
          // A rejected length still spends one busy cycle in DRAIN, touching no memory.
          state_d = len_bad ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        i_d = i_q + 1'b1;
        if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = err_q ? S_DONE : S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (vld_q) begin
      if (first_q || better) begin
        result_d = bus.mem_rdata;
        ridx_d   = sidx_q;
      end
      first_d = 1'b0;
    end
  end

  always_comb begin
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    case (state_q)
      S_READ: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = base_q + i_q;
        bus.busy     = 1'b1;
      end
      S_DRAIN: bus.busy = 1'b1;
      S_WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_addr  = dst_q;
        bus.mem_wdata = result_q;
        bus.busy      = 1'b1;
      end
      S_DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
      end
      default: ;
    endcase
    bus.result     = result_q;
    bus.result_idx = ridx_q;
  end
endmodule

// File: tb/tb_mem_reduce_scan.sv
// tb/tb_mem_reduce_scan.sv - directed and randomized checks of mem_reduce_scan against a reference model
module tb_mem_reduce_scan;
  localparam int WIDTH = 16;
  localparam int DEPTH = 1024;
  localparam int LD    = $clog2(DEPTH);
  localparam int HIST  = 8192;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_reduce_scan_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  mem_reduce_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [WIDTH-1:0] mem [DEPTH];
  logic             tb_we = 1'b0;
  logic [LD-1:0]    tb_waddr = '0;
  logic [WIDTH-1:0] tb_wdata = '0;
  int               rd_hist [HIST];
  int               rd_cnt = 0;
  int               both_cnt = 0;
  int               n_checks = 0;
  int               n_fail = 0;

  always @(posedge clk) begin
    if (tb_we) mem[tb_waddr] <= tb_wdata;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      rd_hist[rd_cnt % HIST] <= int'(bus.mem_addr);
      rd_cnt <= rd_cnt + 1;
    end
    if (bus.mem_re && bus.mem_we) both_cnt <= both_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic poke(input int a, input logic [WIDTH-1:0] v);
    tb_waddr = LD'(a);
    tb_wdata = v;
    tb_we    = 1'b1;
    step();
    tb_we    = 1'b0;
  endtask

  // Reference: first strictly-better element of the window, wrapping modulo DEPTH.
  task automatic ref_scan(input logic [1:0] m, input int b, input int l,
                          output logic [WIDTH-1:0] r, output int ix);
    int  best;
    int  key;
    bit  have;
    logic [WIDTH-1:0] v;
    have = 0; best = 0; r = '0; ix = 0;
    for (int j = 0; j < l; j++) begin
      v   = mem[(b + j) % DEPTH];
      key = m[1] ? int'($signed(v)) : int'(v);
      if (!have || (m[0] ? (key < best) : (key > best))) begin
        best = key; r = v; ix = j; have = 1;
      end
    end
  endtask

  // Returns in the DONE cycle (or after the cycle budget runs out, with done_c = -1).
  task automatic run_scan(input logic [1:0] m, input int b, input int l, input int d, input bit hold,
                          output int done_c, output int busy_c, output int nre, output int nwe,
                          output logic err_s);
    bus.mode      = m;
    bus.base_addr = LD'(b);
    bus.length    = (LD+1)'(l);
    bus.dst_addr  = LD'(d);
    bus.start     = 1'b1;
    done_c = -1; busy_c = 0; nre = 0; nwe = 0; err_s = 1'b0;
    step();
    if (!hold) begin
      bus.start     = 1'b0;
      bus.mode      = ~m;
      bus.base_addr = LD'(b + 7);
      bus.length    = (LD+1)'($urandom_range(1, 2047));
      bus.dst_addr  = LD'(~d);
    end
    for (int c = 1; c <= 3000; c++) begin
      if (bus.busy)   busy_c++;
      if (bus.mem_re) nre++;
      if (bus.mem_we) nwe++;
      if (bus.done) begin
        done_c = c;
        err_s  = bus.err;
        break;
      end
      step();
    end
    if (done_c < 0) $display("FAIL scan_timeout: got no done expected done within 3000 cycles");
  endtask

  initial begin
    int dc, bc, nre, nwe, rd0, ix;
    logic es;
    logic [WIDTH-1:0] r;
    logic [15:0] words [8];

    bus.start = 1'b0; bus.mode = '0; bus.base_addr = '0; bus.length = '0; bus.dst_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_result", bus.result, 0);
    check("rst_idx", bus.result_idx, 0);
    check("rst_re_we_addr", {bus.mem_re, bus.mem_we, bus.mem_addr}, 0);
    reset_n = 1'b1;
    step();

    // Full memory, unsigned max with a single peak.
    for (int a = 0; a < DEPTH; a++) poke(a, (a == 700) ? 16'hFFFF : 16'(a & 8'hFF));
    rd0 = rd_cnt;
    run_scan(2'd0, 0, 1024, 0, 0, dc, bc, nre, nwe, es);
    check("full_result", bus.result, 16'hFFFF);
    check("full_idx", bus.result_idx, 700);
    check("full_done_cycle", dc, 1027);
    check("full_busy_cycles", bc, 1026);
    check("full_reads", nre, 1024);
    check("full_writes", nwe, 1);
    check("full_err", es, 0);
    step();
    check("full_mem0", mem[0], 16'hFFFF);
    check("full_first_rd_addr", rd_hist[rd0 % HIST], 0);

    // Signed min across the wrap point, with a tie.
    words = '{16'd5, 16'hFFFD, 16'd7, 16'hFFFD, 16'd0, 16'd2, 16'hFFFF, 16'd4};
    for (int j = 0; j < 8; j++) poke((1020 + j) % DEPTH, words[j]);
    rd0 = rd_cnt;
    run_scan(2'd3, 1020, 8, 600, 0, dc, bc, nre, nwe, es);
    check("smin_result", bus.result, 16'hFFFD);
    check("smin_idx", bus.result_idx, 1);
    check("smin_done_cycle", dc, 11);
    step();
    check("smin_mem_dst", mem[600], 16'hFFFD);
    check("smin_nreads", rd_cnt - rd0, 8);
    for (int j = 0; j < 8; j++) check($sformatf("smin_rd_addr%0d", j), rd_hist[(rd0 + j) % HIST], (1020 + j) % DEPTH);

    // Same two words ranked unsigned then signed.
    poke(200, 16'h8000);
    poke(201, 16'h0001);
    run_scan(2'd0, 200, 2, 300, 0, dc, bc, nre, nwe, es);
    check("umax_result", bus.result, 16'h8000);
    check("umax_idx", bus.result_idx, 0);
    step();
    run_scan(2'd2, 200, 2, 300, 0, dc, bc, nre, nwe, es);
    check("smax_result", bus.result, 16'h0001);
    check("smax_idx", bus.result_idx, 1);
    step();
    check("smax_mem_dst", mem[300], 16'h0001);

    // Illegal lengths: early done with err, no memory traffic, result retained.
    foreach (words[k]) if (k < 2) begin
      run_scan(2'd1, 5, (k == 0) ? 0 : 1025, 10, 0, dc, bc, nre, nwe, es);
      check($sformatf("bad%0d_done_cycle", k), dc, 2);
      check($sformatf("bad%0d_err", k), es, 1);
      check($sformatf("bad%0d_mem_traffic", k), nre + nwe, 0);
      check($sformatf("bad%0d_result_kept", k), {bus.result, 6'd0, bus.result_idx}, {16'h0001, 6'd0, 10'd1});
      step();
      check($sformatf("bad%0d_err_pulse", k), {bus.err, bus.done}, 0);
    end

    // Single word.
    poke(5, 16'h1234);
    run_scan(2'd1, 5, 1, 20, 0, dc, bc, nre, nwe, es);
    check("one_result", bus.result, 16'h1234);
    check("one_idx", bus.result_idx, 0);
    check("one_done_cycle", dc, 4);
    step();
    check("one_mem_dst", mem[20], 16'h1234);

    // start held high: ignored while busy and in DONE, re-accepted from IDLE.
    poke(10, 16'd3); poke(11, 16'd9); poke(12, 16'd1);
    run_scan(2'd0, 10, 3, 30, 1, dc, bc, nre, nwe, es);
    check("hold_done_cycle", dc, 6);
    check("hold_writes", nwe, 1);
    check("hold_result", bus.result, 16'd9);
    step();
    check("hold_idle_gap", {bus.busy, bus.done}, 0);
    step();
    check("hold_reaccept", bus.busy, 1);
    bus.start = 1'b0;
    begin
      int c2;
      c2 = 0;
      while (!bus.done && c2 < 100) begin step(); c2++; end
      check("hold_second_done", bus.done, 1);
    end
    step();

    // Reset during READ cycle 10.
    poke(900, 16'hA5A5);
    bus.mode = 2'd0; bus.base_addr = '0; bus.length = 11'd50; bus.dst_addr = 10'd900; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    check("mid_in_read", bus.mem_re, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_outputs", {bus.busy, bus.done, bus.err, bus.mem_re, bus.mem_we, bus.mem_addr}, 0);
    check("mid_rst_result", {bus.result, bus.result_idx}, 0);
    nwe = 0;
    for (int c = 0; c < 4; c++) begin step(); if (bus.mem_we) nwe++; end
    reset_n = 1'b1;
    for (int c = 0; c < 60; c++) begin step(); if (bus.mem_we || bus.busy) nwe++; end
    check("mid_rst_no_activity", nwe, 0);
    check("mid_rst_mem_dst", mem[900], 16'hA5A5);

    // Randomized scans against the reference model.
    for (int t = 0; t < 12; t++) begin
      int b, l, d, pool;
      logic [1:0] m;
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(1, 40);
      d = $urandom_range(0, DEPTH - 1);
      m = 2'($urandom_range(0, 3));
      pool = $urandom_range(0, 1);
      for (int j = 0; j < l; j++)
        poke((b + j) % DEPTH, pool ? 16'($urandom_range(0, 3) * 16'h5555) : 16'($urandom));
      ref_scan(m, b, l, r, ix);
      rd0 = rd_cnt;
      run_scan(m, b, l, d, 0, dc, bc, nre, nwe, es);
      check($sformatf("rnd%0d_result", t), bus.result, r);
      check($sformatf("rnd%0d_idx", t), bus.result_idx, ix);
      check($sformatf("rnd%0d_timing", t), {dc, bc, nre, nwe}, {l + 3, l + 2, l, 32'd1});
      check($sformatf("rnd%0d_err", t), es, 0);
      step();
      check($sformatf("rnd%0d_mem_dst", t), mem[d], r);
      for (int j = 0; j < l; j++)
        if (rd_hist[(rd0 + j) % HIST] != (b + j) % DEPTH)
          check($sformatf("rnd%0d_rd_addr%0d", t, j), rd_hist[(rd0 + j) % HIST], (b + j) % DEPTH);
      check($sformatf("rnd%0d_nreads", t), rd_cnt - rd0, l);
    end

    check("re_we_exclusive", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
